seq_detect_ctrl: RTL and testbench

Programmable serial-pattern detection controller for the FSM library. It latches a pattern of 1..PAT_W bits, selects overlapping or non-overlapping detection, and sequences a run from start to a target match count. The generalized detector it sequences covers the fixed-pattern detectors, such as 101 non-overlap, as configuration cases. It sits between a register/config master and a qualified serial bit stream, and reports per-match pulses, a running count and a completion flag.

---
 rtl/seq_ctrl_pkg.sv | 16 +
 rtl/seq_match_core.sv | 58 +++++
 rtl/seq_detect_ctrl.sv | 136 +++++++++++++
 tb/tb_seq_detect_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_ctrl_pkg.sv
// rtl/seq_ctrl_pkg.sv - shared types and helpers for the sequence detection controller
package seq_ctrl_pkg;

    localparam int LEN_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic len_ok(input logic [LEN_W-1:0] len, input int max_len);
        return (len != '0) && (int'(len) <= max_len);
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// rtl/seq_match_core.sv - bit history, fill counter and masked pattern comparator
module seq_match_core
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_data,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_overlap,
    output logic             o_hit
);

    // Only PAT_W-1 past bits are stored; the incoming bit completes the window.
    logic [PAT_W-2:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic [PAT_W-1:0] w_hist_nxt;
    logic [PAT_W-1:0] w_mask;
    logic [LEN_W:0]   w_fill_inc;
    logic             w_full;

    assign w_hist_nxt = {r_hist, i_data};
    assign w_fill_inc = {1'b0, r_fill} + 1'b1;
    assign w_full     = (w_fill_inc >= {1'b0, i_len});

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (LEN_W'(i) < i_len);
        end
    end

    assign o_hit = i_en && w_full && ((w_hist_nxt & w_mask) == (i_pattern & w_mask));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_clr) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_en) begin
            r_hist <= w_hist_nxt[PAT_W-2:0];
            if (o_hit && !i_overlap) begin
                r_fill <= '0;
            end else if (w_full) begin
                r_fill <= i_len;
            end else begin
                r_fill <= w_fill_inc[LEN_W-1:0];
            end
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - run FSM, config registers and match counter around the match core
module seq_detect_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_target,
    output logic             cfg_ready,
    output logic             cfg_err,
    input  logic             start,
    input  logic             stop,
    input  logic             data_valid,
    input  logic             data_in,
    output logic             busy,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             done
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PAT_W-1:0] r_pattern;
    logic [LEN_W-1:0] r_len;
    logic             r_overlap;
    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] r_count;
    logic             r_match;
    logic             r_done;
    logic             r_cfg_err;

    logic             w_cfg_acc;
    logic             w_len_ok;
    logic             w_start_go;
    logic             w_en;
    logic             w_hit;
    logic [CNT_W-1:0] w_count_inc;
    logic             w_target_hit;

    assign w_cfg_acc    = cfg_valid && (r_state != RUN);
    assign w_len_ok     = len_ok(cfg_len, PAT_W);
    assign w_start_go   = start && (r_state != RUN);
    // stop gates the core so a same-cycle final bit never counts
    assign w_en         = (r_state == RUN) && data_valid && !stop;
    assign w_count_inc  = (&r_count) ? r_count : r_count + 1'b1;
    assign w_target_hit = w_hit && (r_target != '0) && (w_count_inc == r_target);

    seq_match_core #(
        .PAT_W(PAT_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_start_go),
        .i_en     (w_en),
        .i_data   (data_in),
        .i_pattern(r_pattern),
        .i_len    (r_len),
        .i_overlap(r_overlap),
        .o_hit    (w_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_state_nxt = RUN;
            RUN: begin
                if (stop) begin
                    w_state_nxt = IDLE;
                end else if (w_target_hit) begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pattern <= '0;
            r_len     <= LEN_W'(1);
            r_overlap <= 1'b0;
            r_target  <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_cfg_acc && !w_len_ok;
            if (w_cfg_acc && w_len_ok) begin
                r_pattern <= cfg_pattern;
                r_len     <= cfg_len;
                r_overlap <= cfg_overlap;
                r_target  <= cfg_target;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_match <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_match <= 1'b0;
            if (w_start_go) begin
                r_count <= '0;
                r_done  <= 1'b0;
            end else if (w_hit) begin
                r_match <= 1'b1;
                r_count <= w_count_inc;
                if (w_target_hit) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign cfg_ready   = (r_state != RUN);
    assign cfg_err     = r_cfg_err;
    assign busy        = (r_state == RUN);
    assign match       = r_match;
    assign match_count = r_count;
    assign done        = r_done;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb/tb_seq_detect_ctrl.sv - directed self-checking bench for seq_detect_ctrl
module tb_seq_detect_ctrl;

    localparam int PAT_W = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_valid = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [3:0]       cfg_len = 4'd0;
    logic             cfg_overlap = 1'b0;
    logic [CNT_W-1:0] cfg_target = '0;
    logic             cfg_ready;
    logic             cfg_err;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             data_valid = 1'b0;
    logic             data_in = 1'b0;
    logic             busy;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             done;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .cfg_target (cfg_target),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .start      (start),
        .stop       (stop),
        .data_valid (data_valid),
        .data_in    (data_in),
        .busy       (busy),
        .match      (match),
        .match_count(match_count),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [7:0] pat, input logic [3:0] len,
                             input logic ov, input logic [7:0] tgt);
        cfg_valid = 1'b1; cfg_pattern = pat; cfg_len = len;
        cfg_overlap = ov; cfg_target = tgt;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // drives one qualified bit, then checks the registered outputs after the edge
    task automatic bit_in(input logic b, input string tag, input logic exp_m, input int exp_cnt);
        data_valid = 1'b1; data_in = b;
        tick();
        data_valid = 1'b0;
        check({tag, ".match"}, 32'(match), 32'(exp_m));
        check({tag, ".count"}, 32'(match_count), 32'(exp_cnt));
    endtask

    initial begin
        #2;
        check("rst.busy", 32'(busy), 0);
        check("rst.match", 32'(match), 0);
        check("rst.count", 32'(match_count), 0);
        check("rst.done", 32'(done), 0);
        check("rst.cfg_err", 32'(cfg_err), 0);
        check("rst.cfg_ready", 32'(cfg_ready), 1);
        tick();
        rst = 1'b0;
        tick();

        // 101, non-overlap
        write_cfg(8'b101, 4'd3, 1'b0, 8'd0);
        do_start();
        check("t1.busy", 32'(busy), 1);
        check("t1.ready", 32'(cfg_ready), 0);
        bit_in(1'b1, "t1.b1", 1'b0, 0);
        bit_in(1'b0, "t1.b2", 1'b0, 0);
        bit_in(1'b1, "t1.b3", 1'b1, 1);
        bit_in(1'b0, "t1.b4", 1'b0, 1);
        bit_in(1'b1, "t1.b5", 1'b0, 1);
        do_stop();
        check("t1.idle", 32'(busy), 0);

        // 101, overlap
        write_cfg(8'b101, 4'd3, 1'b1, 8'd0);
        do_start();
        check("t2.clr", 32'(match_count), 0);
        bit_in(1'b1, "t2.b1", 1'b0, 0);
        bit_in(1'b0, "t2.b2", 1'b0, 0);
        bit_in(1'b1, "t2.b3", 1'b1, 1);
        bit_in(1'b0, "t2.b4", 1'b0, 1);
        bit_in(1'b1, "t2.b5", 1'b1, 2);
        do_stop();

        // 11, target 2, non-overlap
        write_cfg(8'b11, 4'd2, 1'b0, 8'd2);
        do_start();
        bit_in(1'b1, "t3.b1", 1'b0, 0);
        bit_in(1'b1, "t3.b2", 1'b1, 1);
        check("t3.done_early", 32'(done), 0);
        bit_in(1'b1, "t3.b3", 1'b0, 1);
        bit_in(1'b1, "t3.b4", 1'b1, 2);
        check("t3.done", 32'(done), 1);
        check("t3.busy", 32'(busy), 0);
        bit_in(1'b1, "t3.b5", 1'b0, 2);
        bit_in(1'b1, "t3.b6", 1'b0, 2);
        check("t3.done_hold", 32'(done), 1);

        // rejected configs in DONE
        write_cfg(8'b101, 4'd0, 1'b1, 8'd0);
        check("t4.err0", 32'(cfg_err), 1);
        tick();
        check("t4.err_pulse", 32'(cfg_err), 0);
        write_cfg(8'b101, 4'd9, 1'b1, 8'd0);
        check("t4.err9", 32'(cfg_err), 1);
        do_start();
        check("t4.done_clr", 32'(done), 0);
        // config write during RUN is ignored silently
        write_cfg(8'b101, 4'd3, 1'b1, 8'd0);
        check("t4.run_err", 32'(cfg_err), 0);
        bit_in(1'b1, "t4.b1", 1'b0, 0);
        bit_in(1'b1, "t4.b2", 1'b1, 1);
        bit_in(1'b1, "t4.b3", 1'b0, 1);
        bit_in(1'b1, "t4.b4", 1'b1, 2);
        check("t4.done", 32'(done), 1);

        // config and start together, then stop on final bit
        cfg_valid = 1'b1; cfg_pattern = 8'b101; cfg_len = 4'd3;
        cfg_overlap = 1'b0; cfg_target = 8'd0;
        start = 1'b1;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        check("t5.busy", 32'(busy), 1);
        check("t5.clr", 32'(match_count), 0);
        bit_in(1'b1, "t5.b1", 1'b0, 0);
        bit_in(1'b0, "t5.b2", 1'b0, 0);
        stop = 1'b1;
        bit_in(1'b1, "t5.b3", 1'b0, 0);
        stop = 1'b0;
        check("t5.idle", 32'(busy), 0);

        // data_valid gaps inside the pattern
        do_start();
        bit_in(1'b1, "t6.b1", 1'b0, 0);
        data_in = 1'b0;
        tick();
        check("t6.gap1", 32'(match), 0);
        bit_in(1'b0, "t6.b2", 1'b0, 0);
        data_in = 1'b1;
        tick();
        tick();
        check("t6.gap2", 32'(match_count), 0);
        bit_in(1'b1, "t6.b3", 1'b1, 1);

        // asynchronous reset mid-run
        #2;
        rst = 1'b1;
        #1;
        check("t7.busy", 32'(busy), 0);
        check("t7.count", 32'(match_count), 0);
        check("t7.ready", 32'(cfg_ready), 1);
        check("t7.done", 32'(done), 0);
        tick();
        rst = 1'b0;
        tick();
        // reset config is pattern 0, len 1: every 0 bit matches
        do_start();
        bit_in(1'b1, "t7.b1", 1'b0, 0);
        bit_in(1'b0, "t7.b2", 1'b1, 1);
        bit_in(1'b0, "t7.b3", 1'b1, 2);
        check("t7.done_tgt0", 32'(done), 0);
        do_stop();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
